// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and the
// seven-segment display path that consumes its packed-BCD word.
package bin_to_bcd_seq_pkg;

  localparam int BIN_WIDTH_DEF = 27;
  localparam int DIGITS_DEF    = 8;

  // FSM encoding, kept as plain vector constants for older tool flows
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  // Largest value representable in the given number of decimal digits
  function automatic longint unsigned max_decimal(input int digits);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

  localparam longint unsigned MAX_DECIMAL = max_decimal(DIGITS_DEF);

  // Digit codes shared with the display driver
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE  = 4'h9;
  localparam logic [4*DIGITS_DEF-1:0] BCD_ALL_NINES = {DIGITS_DEF{BCD_NINE}};

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3_nibble.sv
// Double-dabble digit corrector: a nibble of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
// Arithmetic is 4-bit only; nothing carries between nibbles.
module bcd_add3_nibble
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Conditional +3 correction
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) digit_out = digit_in + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one bit per clock (shift-add-3).
// Results, leading-zero mask and overflow only change on the finish cycle, so
// the downstream display never sees a partially converted value.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start; outputs hold the last result
//   ST_SHIFT  | one correct-and-shift iteration per clock, BIN_WIDTH total
//   ST_FINISH | publish result (or saturated nines), pulse done
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_WIDTH = BIN_WIDTH_DEF,
  parameter int DIGITS    = DIGITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_mask,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [BIN_WIDTH-1:0] MAX_VAL   = BIN_WIDTH'(max_decimal(DIGITS));
  localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(BIN_WIDTH - 1);
  localparam logic [BCD_W-1:0]     NINES     = {DIGITS{BCD_NINE}};
  localparam logic [DIGITS-1:0]    MASK_RST  = DIGITS'(1);

  state_t               state;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0]     bcd_acc;
  logic [BCD_W-1:0]     bcd_corr;
  logic [CNT_W-1:0]     iter_cnt;
  logic                 ovf_pending;
  logic [BCD_W-1:0]     result_word;
  logic [DIGITS-1:0]    mask_next;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_corr
      bcd_add3_nibble u_add3 (
        .digit_in  (bcd_acc[4*g +: 4]),
        .digit_out (bcd_corr[4*g +: 4])
      );
    end
  endgenerate

  assign busy = (state != ST_IDLE);

  // Final word: the accumulated BCD, or saturated nines when out of range
  assign result_word = ovf_pending ? NINES : bcd_acc;

  // Leading-zero mask: a digit is significant if it or any higher digit is nonzero
  always_comb begin
    logic seen;
    seen      = 1'b0;
    mask_next = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen         = seen | (result_word[4*i +: 4] != 4'd0);
      mask_next[i] = seen | (i == 0);
    end
  end

  // Conversion FSM, datapath registers and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bin_sr      <= '0;
      bcd_acc     <= '0;
      iter_cnt    <= '0;
      ovf_pending <= 1'b0;
      done        <= 1'b0;
      bcd_out     <= '0;
      digit_mask  <= MASK_RST;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin_sr      <= bin_in;
            bcd_acc     <= '0;
            iter_cnt    <= '0;
            ovf_pending <= (bin_in > MAX_VAL);
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The accumulator MSB shifted out is dropped; only out-of-range
          // inputs can produce it, and those are replaced by nines anyway.
          bcd_acc  <= {bcd_corr[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};
          bin_sr   <= bin_sr << 1;
          iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == LAST_ITER) state <= ST_FINISH;
        end
        ST_FINISH: begin
          bcd_out    <= result_word;
          digit_mask <= mask_next;
          overflow   <= ovf_pending;
          done       <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: hand-computed BCD words, masks and latency.
module tb_bin_to_bcd_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [26:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic [7:0]  digit_mask;
  logic        overflow;

  int checks = 0;
  int passes = 0;

  bin_to_bcd_seq dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .digit_mask (digit_mask),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present a value and hold start for exactly one rising edge
  task automatic start_conv(input logic [26:0] val);
    @(negedge clock);
    bin_in = val;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Count edges after the accepting edge until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clock);
      #1;
      n++;
      if (done) return;
    end
    n = -1;
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_bcd,
                              input logic [7:0] exp_mask, input logic exp_ovf);
    check({tag, "_bcd"},  bcd_out,    exp_bcd);
    check({tag, "_mask"}, digit_mask, exp_mask);
    check({tag, "_ovf"},  overflow,   exp_ovf);
  endtask

  initial begin
    int n;
    int pulses;

    // Reset values
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd",  bcd_out, 0);
    check("rst_mask", digit_mask, 8'h01);
    check("rst_ovf",  overflow, 0);
    @(negedge clock);
    reset = 1'b0;

    // Zero
    start_conv(27'd0);
    check("zero_busy", busy, 1);
    wait_done(n);
    check("zero_lat", n, 28);
    check_result("zero", 32'h00000000, 8'h01, 1'b0);
    check("zero_busy_done", busy, 0);

    // Full eight-digit value; done lasts one cycle
    start_conv(27'd12345678);
    @(posedge clock); #1;
    check("mid_hold_bcd", bcd_out, 32'h00000000);
    wait_done(n);
    check("full_lat", n, 27);
    check_result("full", 32'h12345678, 8'hFF, 1'b0);
    @(posedge clock); #1;
    check("done_pulse", done, 0);

    // 905 then 99999999 started in the done cycle
    start_conv(27'd905);
    wait_done(n);
    check("b2b1_lat", n, 28);
    check_result("b2b1", 32'h00000905, 8'h07, 1'b0);
    bin_in = 27'd99999999;
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b2_accept", busy, 1);
    wait_done(n);
    check("b2b2_lat", n, 28);
    check_result("b2b2", 32'h99999999, 8'hFF, 1'b0);

    // Overflow saturates, then clears on next result
    start_conv(27'd100000000);
    wait_done(n);
    check("ovf_lat", n, 28);
    check_result("ovf", 32'h99999999, 8'hFF, 1'b1);
    start_conv(27'd42);
    @(posedge clock); #1;
    check("ovf_hold", overflow, 1);
    wait_done(n);
    check("small_lat", n, 27);
    check_result("small", 32'h00000042, 8'h03, 1'b0);

    // Start pulsed mid-conversion is ignored
    start_conv(27'd7);
    repeat (5) @(posedge clock);
    #1;
    start_conv(27'd31415926);
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clock); #1;
      if (done) begin
        pulses++;
        if (pulses == 1) check_result("ign", 32'h00000007, 8'h01, 1'b0);
      end
    end
    check("ign_pulses", pulses, 1);
    check("ign_idle", busy, 0);

    // Reset at cycle 10 of a conversion
    start_conv(27'd86420);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check_result("mrst", 32'h00000000, 8'h01, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    check("mrst_no_done", pulses, 0);
    check("mrst_bcd_after", bcd_out, 32'h00000000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
